// File: rtl/eth_tx_min_pad.sv
// -----------------------------------------------------------------------------
// eth_tx_min_pad
// Sits between the application frame source and the CRC32 adder on the TX path.
// Frames shorter than MIN_LEN bytes (DA..payload, FCS not yet appended) are
// extended with PAD_BYTE up to MIN_LEN, so the frame meets the 64-byte
// Ethernet minimum once the FCS is added. Frames of MIN_LEN bytes or more go
// through byte for byte.
//
// Both sides use a sof/vld/data/eof/rdy byte stream. There is a single output
// register stage, so a byte accepted in cycle N is presented in cycle N+1.
//
// Build option:
//   ETH_TX_PAD_IFG_EN - when defined, the stage holds off new input for
//                       IFG_CYC cycles after each frame's eof byte has been
//                       loaded (GAP state). When undefined there is no GAP
//                       state, no hold-off counter, and IFG_CYC has no effect.
// -----------------------------------------------------------------------------
module eth_tx_min_pad #(
    parameter int          MIN_LEN  = 60,     // minimum frame length before FCS
    parameter logic [7:0]  PAD_BYTE = 8'h00,  // fill value for pad bytes
    parameter int          CNT_W    = 11,     // byte counter width (saturating)
    parameter int          IFG_CYC  = 12      // hold-off cycles after each frame
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_sof,
    input  logic        in_vld,
    input  logic [7:0]  in_data,
    input  logic        in_eof,
    output logic        in_rdy,

    output logic        out_sof,
    output logic        out_vld,
    output logic [7:0]  out_data,
    output logic        out_eof,
    input  logic        out_rdy,

    output logic        pad_pulse,
    output logic        sof_err
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;  // waiting for a sof byte
    localparam logic [1:0] ST_PASS = 2'd1;  // forwarding frame body
    localparam logic [1:0] ST_PAD  = 2'd2;  // generating pad bytes, input stalled

`ifdef ETH_TX_PAD_IFG_EN
    localparam logic [1:0] ST_GAP  = 2'd3;  // inter-frame hold-off, input stalled

    // Hold-off counter runs 0 .. IFG_CYC-1 while in GAP.
    localparam int         IFG_W   = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYC - 1);

    // A zero-length hold-off degenerates to returning straight to IDLE.
    localparam logic [1:0] ST_CLOSE = (IFG_CYC > 0) ? ST_GAP : ST_IDLE;
`else
    localparam logic [1:0] ST_CLOSE = ST_IDLE;

    // Negative hold-off values are meaningless; nothing is built either way.
    if (IFG_CYC < 0) begin : g_ifg_cyc_invalid
    end
`endif

    // Length threshold in the widened counter domain so that cnt+1 never wraps.
    localparam logic [CNT_W:0]   MIN_LEN_W = (CNT_W + 1)'(MIN_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // A single sof+eof byte already satisfies the minimum only if MIN_LEN <= 1.
    localparam bit ONE_BYTE_MEETS_MIN = (MIN_LEN <= 1);

    // -------------------------------------------------------------------------
    // Registers and next-state signals
    // -------------------------------------------------------------------------
    logic [1:0]        state_reg,     state_next;
    logic [CNT_W-1:0]  cnt_reg,       cnt_next;
    logic              out_vld_reg,   out_vld_next;
    logic              out_sof_reg,   out_sof_next;
    logic              out_eof_reg,   out_eof_next;
    logic [7:0]        out_data_reg,  out_data_next;
    logic              pad_pulse_reg, pad_pulse_next;
    logic              sof_err_reg,   sof_err_next;
`ifdef ETH_TX_PAD_IFG_EN
    logic [IFG_W-1:0]  ifg_cnt_reg,   ifg_cnt_next;
`endif

    // Helper terms
    logic              load_ok;     // output register may take a new value
    logic              in_accept;   // input byte transferred this cycle
    logic [CNT_W:0]    cnt_inc;     // cnt+1 without wrap
    logic [CNT_W-1:0]  cnt_sat;     // cnt+1 saturating at CNT_MAX
    logic              len_reached; // the byte being emitted reaches MIN_LEN

    // Output register is free when empty or being drained this cycle.
    assign load_ok     = !out_vld_reg || out_rdy;

    // Input is only taken while forwarding is possible; held low during reset.
    assign in_rdy      = rst_n && load_ok &&
                         ((state_reg == ST_IDLE) || (state_reg == ST_PASS));
    assign in_accept   = in_vld && in_rdy;

    // Byte counting: the byte about to be emitted is number cnt+1.
    assign cnt_inc     = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, 1'b1};
    assign cnt_sat     = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_inc[CNT_W-1:0];
    assign len_reached = (cnt_inc >= MIN_LEN_W);

    // -------------------------------------------------------------------------
    // Next-state and output-register load logic
    // -------------------------------------------------------------------------
    // Computes the frame FSM transition and what the output register loads.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        out_vld_next   = out_vld_reg;
        out_sof_next   = out_sof_reg;
        out_eof_next   = out_eof_reg;
        out_data_next  = out_data_reg;
        pad_pulse_next = 1'b0;
        sof_err_next   = 1'b0;
`ifdef ETH_TX_PAD_IFG_EN
        ifg_cnt_next   = '0;
`endif

        // When the output register is free and nothing new is loaded below,
        // it empties. When stalled, everything above simply holds.
        if (load_ok) begin
            out_vld_next  = 1'b0;
            out_sof_next  = 1'b0;
            out_eof_next  = 1'b0;
            out_data_next = 8'h00;
        end

        case (state_reg)
            ST_IDLE: begin
                if (in_accept) begin
                    if (in_sof) begin
                        // First byte of a new frame.
                        out_vld_next  = 1'b1;
                        out_sof_next  = 1'b1;
                        out_data_next = in_data;
                        cnt_next      = CNT_ONE;
                        if (in_eof) begin
                            if (ONE_BYTE_MEETS_MIN) begin
                                out_eof_next = 1'b1;
                                state_next   = ST_CLOSE;
                            end else begin
                                pad_pulse_next = 1'b1;
                                state_next     = ST_PAD;
                            end
                        end else begin
                            state_next = ST_PASS;
                        end
                    end else begin
                        // Body byte with no frame open: drop it and flag.
                        sof_err_next = 1'b1;
                    end
                end
            end

            ST_PASS: begin
                if (in_accept) begin
                    // A stray sof inside a frame is forwarded as plain data.
                    out_vld_next  = 1'b1;
                    out_sof_next  = 1'b0;
                    out_data_next = in_data;
                    sof_err_next  = in_sof;
                    cnt_next      = cnt_sat;
                    if (in_eof) begin
                        if (len_reached) begin
                            out_eof_next = 1'b1;
                            state_next   = ST_CLOSE;
                        end else begin
                            pad_pulse_next = 1'b1;
                            state_next     = ST_PAD;
                        end
                    end
                end
            end

            ST_PAD: begin
                if (load_ok) begin
                    out_vld_next  = 1'b1;
                    out_sof_next  = 1'b0;
                    out_data_next = PAD_BYTE;
                    cnt_next      = cnt_sat;
                    if (len_reached) begin
                        out_eof_next = 1'b1;
                        state_next   = ST_CLOSE;
                    end
                end
            end

`ifdef ETH_TX_PAD_IFG_EN
            ST_GAP: begin
                if (ifg_cnt_reg == IFG_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    ifg_cnt_next = ifg_cnt_reg + 1'b1;
                end
            end
`endif

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    // Registers all state; synchronous active-low reset returns to IDLE empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            out_vld_reg   <= 1'b0;
            out_sof_reg   <= 1'b0;
            out_eof_reg   <= 1'b0;
            out_data_reg  <= 8'h00;
            pad_pulse_reg <= 1'b0;
            sof_err_reg   <= 1'b0;
`ifdef ETH_TX_PAD_IFG_EN
            ifg_cnt_reg   <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            out_vld_reg   <= out_vld_next;
            out_sof_reg   <= out_sof_next;
            out_eof_reg   <= out_eof_next;
            out_data_reg  <= out_data_next;
            pad_pulse_reg <= pad_pulse_next;
            sof_err_reg   <= sof_err_next;
`ifdef ETH_TX_PAD_IFG_EN
            ifg_cnt_reg   <= ifg_cnt_next;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_vld   = out_vld_reg;
    assign out_sof   = out_sof_reg;
    assign out_eof   = out_eof_reg;
    assign out_data  = out_data_reg;
    assign pad_pulse = pad_pulse_reg;
    assign sof_err   = sof_err_reg;

endmodule
